// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: FSM encodings and a constant-width helper.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor (d = a - b - bin); chained to build the trial subtract.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Define DIV_SIGNED_EN for two's-complement operands (sign fix-up on the DONE edge).
module seq_restoring_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic             r_dz;

  logic [WIDTH:0]   w_x;
  logic [WIDTH:0]   w_y;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH+1:0] w_b;
  logic             w_borrow;
  logic             w_unused;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_d_in;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  // Shifted partial remainder minus divisor, WIDTH+1 bits; borrow-out selects restore.
  assign w_x    = {r_r, r_a[WIDTH-1]};
  assign w_y    = {1'b0, r_d};
  assign w_b[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_sub
      full_sub u_fs (
        .a    (w_x[gi]),
        .b    (w_y[gi]),
        .bin  (w_b[gi]),
        .d    (w_diff[gi]),
        .bout (w_b[gi+1])
      );
    end
  endgenerate

  assign w_borrow = w_b[WIDTH+1];
  assign w_unused = w_diff[WIDTH];
  assign w_a_next = {r_a[WIDTH-2:0], ~w_borrow};
  assign w_r_next = w_borrow ? w_x[WIDTH-1:0] : w_diff[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  logic r_qneg;
  logic r_rneg;

  assign w_a_in  = dataA[WIDTH-1] ? -dataA : dataA;
  assign w_d_in  = dataB[WIDTH-1] ? -dataB : dataB;
  assign w_q_fin = r_qneg ? -w_a_next : w_a_next;
  assign w_r_fin = r_rneg ? -w_r_next : w_r_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (r_state == ST_IDLE && !r_dz && start) begin
      r_qneg <= dataA[WIDTH-1] ^ dataB[WIDTH-1];
      r_rneg <= dataA[WIDTH-1];
    end
  end
`else
  assign w_a_in  = dataA;
  assign w_d_in  = dataB;
  assign w_q_fin = w_a_next;
  assign w_r_fin = w_r_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_dz        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A zero divisor is held one cycle so its done lands on the edge after accept.
          if (r_dz) begin
            r_dz        <= 1'b0;
            r_state     <= ST_DONE;
            done        <= 1'b1;
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= r_a;
          end else if (start) begin
            r_a         <= (dataB == '0) ? dataA : w_a_in;
            r_d         <= w_d_in;
            r_r         <= '0;
            r_cnt       <= '0;
            div_by_zero <= 1'b0;
            if (dataB != '0) begin
              r_state <= ST_RUN;
              busy    <= 1'b1;
            end else begin
              r_dz <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_a   <= w_a_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state   <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= w_q_fin;
            remainder <= w_r_fin;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed-vector bench for seq_restoring_divider at WIDTH=8 (signed vectors under DIV_SIGNED_EN).
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int overlap  = 0;
  bit busy_seen = 1'b0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dataA       (dataA),
    .dataB       (dataB),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (busy === 1'b1 && done === 1'b1) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input int elat);
    int cyc;
    int d0;
    @(negedge clk);
    dataA = a;
    dataB = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    busy_seen = 1'b0;
    d0 = done_cnt;
    start = 1'b0;
    dataA = ~a;
    dataB = ~b;
    check({tag, "_busy_t0"}, 32'(busy), 32'(b != '0));
    check({tag, "_done_t0"}, 32'(done), 32'd0);
    wait_done(cyc);
    check({tag, "_lat"}, 32'(cyc), 32'(elat));
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
    if (b == '0) check({tag, "_busy_seen"}, 32'(busy_seen), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int cyc;
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    dataA = '0;
    dataB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    do_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    do_op("d3_10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 8);
    do_op("d0_9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 8);
    do_op("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);

    // start held high through RUN and DONE: only the first op runs, next accepted at T10
    @(negedge clk);
    dataA = 8'd100;
    dataB = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    dataA = 8'd50;
    dataB = 8'd5;
    wait_done(cyc);
    check("hold_lat", 32'(cyc), 32'd8);
    check("hold_q", 32'(quotient), 32'd14);
    check("hold_r", 32'(remainder), 32'd2);
    @(posedge clk);
    #1;
    check("hold_busy_t9", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("hold_busy_t10", 32'(busy), 32'd1);
    check("hold_done_cnt", 32'(done_cnt - d0), 32'd1);
    start = 1'b0;
    wait_done(cyc);
    check("next_lat", 32'(cyc), 32'd8);
    check("next_q", 32'(quotient), 32'd10);
    check("next_r", 32'(remainder), 32'd0);
    @(posedge clk);
    #1;

    // reset mid-RUN aborts without a done pulse
    @(negedge clk);
    dataA = 8'd200;
    dataB = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    rst = 1'b1;
    #1;
    d0 = done_cnt;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    do_op("d200_3", 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 8);

`ifdef DIV_SIGNED_EN
    do_op("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 8);
    do_op("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
`else
    do_op("u249_2", 8'hF9, 8'd2, 8'd124, 8'd1, 1'b0, 8);
    do_op("u255_200", 8'd255, 8'd200, 8'd1, 8'd55, 1'b0, 8);
`endif

    check("busy_done_overlap", 32'(overlap), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
